// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : fp_pkg
//  Description: Shared FP32 width and default sizing for the FP adder stream
//               controller and its result FIFO.
//  Revision   : 1.0 - initial release
// ============================================================================
package fp_pkg;

  // Width of an IEEE-754 single-precision word
  localparam int c_fp_width = 32;

  // Default result FIFO depth (power of two, at least adder latency + 1)
  localparam int c_default_depth = 4;

  // Default adder latency, in clock edges from operand capture to valid result
  localparam int c_default_lat = 2;

  typedef logic [c_fp_width-1:0] fp32_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module     : fp_result_fifo
//  Description: DEPTH x 32 first-word-fall-through FIFO holding adder results.
//               pop_data shows the oldest entry whenever count is non-zero
//               and reads as zero when empty.
//  Revision   : 1.0 - initial release
// ============================================================================
module fp_result_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = c_default_depth
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [c_fp_width-1:0]     push_data,
  input  logic                      pop,
  output logic [c_fp_width-1:0]     pop_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [c_fp_width-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_cnt_w'(DEPTH));

  // A pop on an empty FIFO is ignored; a push into a full FIFO is only taken
  // when the same edge also frees a slot.
  assign w_do_pop  = pop && !w_empty;
  assign w_do_push = push && (!w_full || w_do_pop);

  assign pop_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count    = r_count;

  // Storage array: written on push, no reset needed since reads are gated by count
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : fp_result_fifo
`default_nettype wire

// File: rtl/fpadd_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : fpadd_stream_ctrl
//  Description: Stream controller around an external pipelined FP32 adder.
//               Operands go straight to the adder; a valid shift register
//               tracks in-flight ops and pushes the adder output into a
//               result FIFO. Credit-based in_ready guarantees every in-flight
//               op has a FIFO slot reserved, so the FIFO cannot overflow.
//  Revision   : 1.0 - initial release
// ============================================================================
module fpadd_stream_ctrl
  import fp_pkg::*;
#(
  parameter int DEPTH = c_default_depth,
  parameter int LAT   = c_default_lat
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [c_fp_width-1:0]     in_a,
  input  logic [c_fp_width-1:0]     in_b,
  output logic [c_fp_width-1:0]     add_a,
  output logic [c_fp_width-1:0]     add_b,
  input  logic [c_fp_width-1:0]     add_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [c_fp_width-1:0]     out_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int c_cnt_w = $clog2(DEPTH) + 1;
  localparam int c_occ_w = $clog2(DEPTH + LAT + 1) + 1;

  logic [LAT-1:0]     r_inflight;
  logic [c_occ_w-1:0] w_inflight_cnt;
  logic [c_occ_w-1:0] w_occupancy;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [c_cnt_w-1:0] w_count;

  // The adder registers its own operands, so they are forwarded untouched
  assign add_a = in_a;
  assign add_b = in_b;

  // Count ops already in the adder pipeline; each one owns a future FIFO slot
  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < LAT; i++) begin
      w_inflight_cnt = w_inflight_cnt + c_occ_w'(r_inflight[i]);
    end
  end

  assign w_occupancy = c_occ_w'(w_count) + w_inflight_cnt;

  // Ready depends only on registered state (and reset), never on out_ready/in_valid
  assign in_ready = reset && (w_occupancy < c_occ_w'(DEPTH));
  assign w_accept = in_valid && in_ready;

  // The oldest tracked op has its sum on add_out this cycle
  assign w_push    = r_inflight[LAT-1];
  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign count     = w_count;

  generate
    if (LAT == 1) begin : g_lat_one
      // Single-stage tracker: the op accepted last edge is pushed this edge
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_inflight <= '0;
        end else begin
          r_inflight <= w_accept;
        end
      end
    end else begin : g_lat_multi
      // Shift accepted-op markers along the adder's pipeline depth
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_inflight <= '0;
        end else begin
          r_inflight <= {r_inflight[LAT-2:0], w_accept};
        end
      end
    end
  endgenerate

  fp_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (add_out),
    .pop       (w_pop),
    .pop_data  (out_data),
    .count     (w_count)
  );

endmodule : fpadd_stream_ctrl
`default_nettype wire

// File: tb/tb_fpadd_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : tb_fpadd_stream_ctrl
//  Description: Self-checking bench for fpadd_stream_ctrl with a behavioural
//               LAT-stage FP32 adder and an ordered scoreboard of sums.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_fpadd_stream_ctrl;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a      = '0;
  logic [31:0] in_b      = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_out;
  logic [31:0] out_data;
  logic [$clog2(DEPTH):0] count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  fpadd_stream_ctrl #(
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_out   (add_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // FP32 helpers (normal numbers and zero only)
  function automatic real fp32_to_real(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_fp32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [10:0] e32;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'd0) return {d[63], 31'd0};
    e32 = e - 11'd896;
    return {d[63], e32[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return real_to_fp32(fp32_to_real(a) + fp32_to_real(b));
  endfunction

  function automatic logic [31:0] i2f(input int v);
    return real_to_fp32($itor(v));
  endfunction

  // External adder: captures operands at an edge, result valid LAT-1 edges later
  logic [31:0] r_stage [LAT];
  always @(posedge clk) begin
    r_stage[0] <= fp_add(add_a, add_b);
    for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
  end
  assign add_out = r_stage[LAT-1];

  // Scoreboard: push on accept, pop and compare on every output handshake
  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (in_valid && in_ready) sb.push_back(fp_add(in_a, in_b));
      checks++;
      if (int'(count) > DEPTH) begin
        errors++;
        $display("FAIL occupancy: count=%0d, limit %0d", count, DEPTH);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h, no result pending", out_data);
        end else begin
          logic [31:0] exp_v;
          exp_v = sb.pop_front();
          if (out_data !== exp_v) begin
            errors++;
            $display("FAIL result_order: got %h, expected %h", out_data, exp_v);
          end
        end
      end
    end
  end

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rst_count: got %0d, expected 0", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h, expected 0", out_data); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b, expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %b, expected 0", out_valid); end
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_op();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'h40400000;
    in_b      = 32'h3F800000;
    @(posedge clk); #1;              // edge k: accepted
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_k: got %b, expected 0", out_valid); end
    @(posedge clk); #1;              // edge k+1
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_k1: got %b, expected 0", out_valid); end
    @(posedge clk); #1;              // edge k+2: result visible
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, expected 1", out_valid); end
    checks++; if (out_data !== 32'h40800000) begin errors++; $display("FAIL single_data: got %h, expected 40800000", out_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d, expected 1", count); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: count %0d valid %b, expected 0 0", count, out_valid); end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_a = i2f(n_acc + 1);
      in_b = i2f(100);
      @(negedge clk);
      if (n_acc >= 4) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: cycle %0d got %b, expected 0", i, in_ready); end
      end
      if (in_ready) n_acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (n_acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d, expected 4", n_acc); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d, expected 4", count); end
    checks++; if (out_data !== i2f(101)) begin errors++; $display("FAIL bp_head: got %h, expected %h", out_data, i2f(101)); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && count != 0; c++) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || sb.size() != 0) begin errors++; $display("FAIL bp_drain: count %0d pending %0d, expected 0 0", count, sb.size()); end
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = i2f(201 + i);
      in_b     = i2f(0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (LAT + 1) begin @(posedge clk); #1; end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_prefill: got %0d, expected 3", count); end
    in_valid = 1'b1;
    in_a     = i2f(204);
    in_b     = i2f(0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_before: got %b, expected 1", in_ready); end
    @(posedge clk); #1;              // edge k: fourth op accepted
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after: got %b, expected 0", in_ready); end
    @(posedge clk); #1;              // edge k+1
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_count_k1: got %0d, expected 3", count); end
    out_ready = 1'b1;
    @(posedge clk); #1;              // edge k+2: push and pop together
    out_ready = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_count_pushpop: got %0d, expected 3", count); end
    checks++; if (out_data !== i2f(202)) begin errors++; $display("FAIL full_head: got %h, expected %h", out_data, i2f(202)); end
    @(posedge clk); #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_count_hold: got %0d, expected 3", count); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && count != 0; c++) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || sb.size() != 0) begin errors++; $display("FAIL full_drain: count %0d pending %0d, expected 0 0", count, sb.size()); end
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = i2f(7);
    in_b      = i2f(8);
    @(posedge clk); #1;              // edge k: accepted
    in_valid = 1'b0;
    @(posedge clk); #1;              // edge k+1
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b, expected 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d, expected 0", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b, expected 0", in_ready); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h, expected 0", out_data); end
    sb.delete();
    #1;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_release_ready: got %b, expected 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
        errors++;
        $display("FAIL rmid_stale: cycle %0d valid %b count %0d, expected 0 0", i, out_valid, count);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        in_valid = 1'b1;
        in_a     = i2f(i * 3);
        in_b     = i2f(5);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: op %0d got %b, expected 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== i2f((i - 2) * 3 + 5)) begin
          errors++;
          $display("FAIL b2b_stream: slot %0d valid %b data %h, expected 1 %h", i - 2, out_valid, out_data, i2f((i - 2) * 3 + 5));
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || sb.size() != 0) begin errors++; $display("FAIL b2b_drain: count %0d pending %0d, expected 0 0", count, sb.size()); end
  endtask

  task automatic test_random();
    int n_acc = 0;
    int cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = i2f(int'($urandom_range(0, 200000)) - 100000);
      in_b      = i2f(int'($urandom_range(0, 200000)) - 100000);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) n_acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (n_acc != 10000) begin errors++; $display("FAIL rand_timeout: accepted %0d, expected 10000", n_acc); end
    for (int c = 0; c < 50 && (count != 0 || sb.size() != 0); c++) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || sb.size() != 0) begin errors++; $display("FAIL rand_drain: count %0d pending %0d, expected 0 0", count, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fpadd_stream_ctrl
`default_nettype wire

// File: doc/fpadd_stream_ctrl.md
FPADD_STREAM_CTRL -- requirements
Module: fpadd_stream_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning result FIFO entries (power of two, >= LAT+1).
REQ-002 The block SHALL have parameter LAT, default 2, meaning adder latency in clock edges from operand capture to valid adder out.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-006 The block SHALL have port in_ready  output  1  block accepts operand pair this cycle.
REQ-007 The block SHALL have ports in_a, in_b  input  32 each  FP32 operands.
REQ-008 The block SHALL have ports add_a, add_b  output  32 each  operands to adder reg_A/reg_B.
REQ-009 The block SHALL have port add_out  input  32  adder result (adder out).
REQ-010 The block SHALL have port out_valid  output  1  out_data holds a result.
REQ-011 The block SHALL have port out_ready  input  1  downstream consumes result.
REQ-012 The block SHALL have port out_data  output  32  FP32 sum, oldest first.
REQ-013 The block SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-014 The block SHALL accept an operand pair when in_valid=1 and in_ready=1 at a rising edge.
REQ-015 The block SHALL drive add_a=in_a and add_b=in_b combinationally; the adder registers them itself.
REQ-016 The block SHALL track in-flight ops in a LAT-bit valid shift register: bit0 <= accept, bit[i] <= bit[i-1].
REQ-017 The block SHALL push add_out into the FIFO at every edge where bit[LAT-1]=1; no other push source.
REQ-018 Accept at edge k SHALL produce the push at edge k+LAT; with FIFO empty, out_valid=1 after edge k+LAT (first-word-fall-through).
REQ-019 The block SHALL drive in_ready = (count + popcount(valid shift register)) < DEPTH, with no combinational dependence on out_ready or in_valid.
REQ-020 The block SHALL pop on out_valid=1 and out_ready=1; out_valid = (count != 0).
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-022 Pointers SHALL wrap modulo DEPTH; FIFO overflow SHALL be impossible by construction (REQ-019).
REQ-023 Pop while empty SHALL have no effect.
REQ-024 With out_ready held 1, sustained throughput SHALL be one result per cycle.
REQ-025 The block SHALL not inspect or modify FP values; special values pass through unchanged.

Reset
REQ-026 Asserting reset (0) SHALL immediately clear the valid shift register, FIFO pointers and count.
REQ-027 During reset, out_valid=0, count=0, in_ready=0; out_data SHALL be 0.
REQ-028 In-flight operations at reset SHALL be discarded, never pushed after deassertion.
REQ-029 After reset deassertion, in_ready SHALL be 1 from the first cycle.

Structure
REQ-030 FP32 width, default DEPTH and LAT SHALL live in shared package fp_pkg.
REQ-031 The FIFO SHALL be a separate sub-module fp_result_fifo (DEPTH x 32, count output); control stays in the top.

Verification
REQ-032 Single op: in_a=0x40400000, in_b=0x3F800000 accepted at edge k -> out_data=0x40800000, out_valid=1 after edge k+2, count=1.
REQ-033 Backpressure: out_ready=0, in_valid=1 for 8 cycles -> exactly 4 accepted, in_ready=0 after the 4th, then 4 results out in order with no loss.
REQ-034 Full with push+pop: DEPTH=4, count=3, one in flight, out_ready=1 -> count stays 3, order preserved, no overflow.
REQ-035 Reset mid-operation: assert reset one edge after an accept -> out_valid=0, count=0, no stale result appears after release.
REQ-036 Streaming: 16 back-to-back pairs, out_ready=1 -> 16 correct results on 16 consecutive cycles starting 2 edges after the first accept.
REQ-037 Random in_valid/out_ready for 10k ops -> scoreboard match against reference sums, never count > DEPTH.
